// File: rtl/ids_lab05_rr_arbiter_pkg.sv
// ids_lab05_rr_arbiter_pkg
//   Shared definitions for the two-requester round-robin arbiter:
//   the FSM state encoding and the default hold limit.
package ids_lab05_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN  = 2'b01,
      REL  = 2'b10
   } state_t;

   // Default maximum number of owned cycles before a waiting requester
   // may preempt the owner.
   localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/ids_lab05_dec1to2_en.sv
// ids_lab05_dec1to2_en
//   1-to-2 decoder with enable, used to build the one-hot grant.
//   A  : select input
//   E  : enable; both outputs low when E=0
//   D0 : high when E=1 and A=0
//   D1 : high when E=1 and A=1
module ids_lab05_dec1to2_en (
   input  logic A,
   input  logic E,
   output logic D0,
   output logic D1
);

   assign D0 = E & ~A;
   assign D1 = E &  A;

endmodule

// File: rtl/ids_lab05_rr_arbiter.sv
// ids_lab05_rr_arbiter
//   Two-requester round-robin arbiter with a bounded hold time.
//   A requester owns the resource until it signals done or drops its
//   request; if the other requester is waiting and the owner has held
//   for MAX_HOLD cycles, the owner is forcibly released (preempt pulse).
//   Every release passes through one REL cycle and one IDLE cycle.
//
//   Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   req     : req[i]=1 -> requester i wants the resource
//   done    : done[i]=1 -> requester i releases (only honoured for the owner)
//   gnt     : one-hot registered grant, 00 = no owner
//   gnt_id  : index of current or last owner
//   busy    : high while in OWN
//   preempt : one-cycle pulse in the REL cycle following a forced release
module ids_lab05_rr_arbiter
   import ids_lab05_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int CW       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] done,
   output logic [1:0] gnt,
   output logic       gnt_id,
   output logic       busy,
   output logic       preempt
);

   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   state_t        state, state_nxt;
   logic          id_nxt;
   logic          pre_nxt;
   logic          prio;
   logic [CW-1:0] cnt;
   logic          dec0, dec1;

   // Next-state / next-owner evaluation. Kept combinational so the grant
   // decode can be registered in the same edge that enters OWN.
   always_comb begin
      state_nxt = state;
      id_nxt    = gnt_id;
      pre_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               state_nxt = OWN;
               id_nxt    = (req == 2'b11) ? prio : req[1];
            end
         end
         OWN: begin
            // Owner release (done or dropped request) wins over preemption,
            // so a simultaneous done is reported as a normal release.
            if (done[gnt_id] || !req[gnt_id]) begin
               state_nxt = REL;
            end else if ((cnt == HOLD_LAST) && req[~gnt_id]) begin
               state_nxt = REL;
               pre_nxt   = 1'b1;
            end
         end
         REL:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   ids_lab05_dec1to2_en u_dec (
      .A  (id_nxt),
      .E  (state_nxt == OWN),
      .D0 (dec0),
      .D1 (dec1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= 2'b00;
         gnt_id  <= 1'b0;
         busy    <= 1'b0;
         preempt <= 1'b0;
         cnt     <= '0;
         prio    <= 1'b0;
      end else begin
         state   <= state_nxt;
         gnt_id  <= id_nxt;
         gnt     <= {dec1, dec0};
         busy    <= (state_nxt == OWN);
         preempt <= pre_nxt;
         case (state)
            OWN: begin
               // Hold counter saturates at the last allowed cycle.
               if (state_nxt == OWN && cnt != HOLD_LAST)
                  cnt <= cnt + 1'b1;
            end
            REL: begin
               cnt  <= '0;
               prio <= ~gnt_id;
            end
            default: ;
         endcase
      end
   end

endmodule
